sdram_ctrl_if_gen: RTL and testbench
====================================

Name: sdram_ctrl_if_gen

Overview:
Parametrised SDRAM command/control interface between the user-side frame-buffer command port and the SDRAM command sequencer.
- Registers and decodes host commands and the address.
- Generates the power-up init sequence (PRECHARGE, N×REFRESH, LOAD_MODE). Timing and refresh count are parameters.
- Replaces the single-shot refresh request with a free-running refresh scheduler and a postponed-refresh backlog counter, with urgent and overflow flags.
- Supports re-running init without a hard reset.

Parameters:
ASIZE, 23, host/SDRAM address width.
INIT_PER, 24000, power-up wait cycles (INIT_REQ high).
INIT_STEP, 20, cycles between init commands.
INIT_REF_CNT, 8, auto-refreshes issued during init (≥1).
REF_PER, 1024, refresh interval in cycles (≥2).
REF_BACKLOG_MAX, 4, maximum postponed refreshes held (≥1).
Derived: PW = $clog2(REF_BACKLOG_MAX+1); TAIL = (INIT_REF_CNT+2)*INIT_STEP; T_LMR = INIT_PER+TAIL; T_DONE = T_LMR+1.

Ports:
CLK  in  1  clock
RESET_N  in  1  async active-low reset
CMD  in  3  host command: 000 NOP, 001 READA, 010 WRITEA, other values reserved
ADDR  in  ASIZE  host address
CM_ACK  in  1  command accepted, from sequencer
REF_ACK  in  1  one-cycle pulse, one refresh serviced
INIT_RESTART  in  1  one-cycle pulse, re-run init sequence
NOP, READA, WRITEA  out  1  registered command decode
SADDR  out  ASIZE  registered ADDR
REFRESH, PRECHARGE, LOAD_MODE  out  1  init command pulses
INIT_REQ  out  1  high during power-up wait
CMD_ACK  out  1  host acknowledge
REF_REQ  out  1  refresh needed (REF_PENDING ≠ 0)
REF_URGENT  out  1  REF_PENDING == REF_BACKLOG_MAX
REF_PENDING  out  PW  postponed refresh count
REF_OVF  out  1  sticky: refresh expired while backlog saturated
Sdram_Init_Done  out  1  init complete

Behaviour:
Reset and clocking:
- Reset is asynchronous, active-low on RESET_N; clock is CLK.
- All registered outputs reset to 0: init_cnt=0, ref_timer=0, REF_PENDING=0, REF_OVF=0.
- Edge n = nth rising edge after reset release. Registered outputs reflect state sampled before the edge.

Command path (1-cycle latency):
- SADDR <= ADDR on every edge.
- NOP <= (CMD==000).
- READA <= (CMD==001) & Sdram_Init_Done; WRITEA <= (CMD==010) & Sdram_Init_Done.
- Reserved CMD values drive all three outputs to 0.

CMD_ACK:
- CMD_ACK <= CM_ACK & ~CMD_ACK.
- Result: a one-cycle pulse, which repeats every 2 cycles while CM_ACK is held high.

Init sequencer:
- init_cnt increments each edge, saturating at T_DONE.
- Outputs are registered from the pre-edge init_cnt value c:
  - INIT_REQ = (c < INIT_PER).
  - PRECHARGE = (c == INIT_PER+INIT_STEP).
  - REFRESH = (c == INIT_PER+k*INIT_STEP) for k = 2..INIT_REF_CNT+1.
  - LOAD_MODE = (c == T_LMR).
  - Otherwise all four are 0.
- Init pulses are exactly one cycle wide and mutually exclusive.
- Sdram_Init_Done = (init_cnt == T_DONE), combinational. It rises on the same edge LOAD_MODE is asserted.
- INIT_RESTART at any time:
  - init_cnt <= 0 and REF_PENDING <= 0 on the next edge.
  - Done drops immediately after that edge.
  - The sequence replays fully. An in-flight init pulse completes its single cycle.
  - REF_OVF is not cleared.

Refresh scheduler:
- While INIT_REQ=1: ref_timer <= REF_PER-1+TAIL.
- Otherwise, if ref_timer == 0: expiry, and ref_timer <= REF_PER-1.
- Otherwise: ref_timer decrements.
- The timer is free-running; REF_ACK does not reload it. The refresh rate is therefore independent of service latency. Period = REF_PER cycles.
- Backlog update rules:
  - Expiry only: REF_PENDING +1. If it is already REF_BACKLOG_MAX, it holds and REF_OVF <= 1.
  - REF_ACK only: REF_PENDING −1 if nonzero; REF_ACK at 0 is ignored.
  - Expiry and REF_ACK in the same cycle: REF_PENDING unchanged, no overflow.
- REF_OVF is cleared only by RESET_N.

Test Plan:
1. Init sequence. INIT_PER=10, INIT_STEP=4, INIT_REF_CNT=2, reset released → INIT_REQ high after edges 1..10, low after edge 11. PRECHARGE pulse after edge 15. REFRESH pulses after edges 19 and 23. LOAD_MODE pulse and Sdram_Init_Done rise after edge 27. Done stays 1.
2. Command decode. Before done, CMD=001 → READA=0, NOP=0. After done, CMD=001 with ADDR=0x012345 → next cycle READA=1, SADDR=0x012345. CMD=101 → NOP=READA=WRITEA=0. CMD=000 → NOP=1.
3. CMD_ACK. CM_ACK held high 4 cycles → CMD_ACK sequence 1,0,1,0; then 0 once CM_ACK drops.
4. Refresh backlog. Same params plus REF_PER=8, REF_BACKLOG_MAX=2, no REF_ACK:
   - REF_PENDING=1 and REF_REQ=1 after edge 35.
   - REF_PENDING=2 and REF_URGENT=1 after edge 43.
   - At edge 51: pending stays 2, REF_OVF=1.
   - A REF_ACK pulse then → pending 1, URGENT=0, OVF remains 1.
5. Simultaneous events. REF_ACK coincident with expiry at edge 43 → REF_PENDING remains 1. Four further REF_ACK pulses when pending is 0 → pending stays 0, no underflow.
6. Restart and reset. INIT_RESTART pulsed after done with pending=1 → done=0, pending=0, INIT_REQ=1, full sequence replays with identical spacing. RESET_N asserted mid-sequence → all outputs 0 immediately (asynchronous), and the sequence restarts from edge 1.

Source files
------------

// File: rtl/sdram_ctrl_if_gen.sv
// ============================================================================
// sdram_ctrl_if_gen : SDRAM host command decode, power-up init sequencer and
//                     free-running refresh scheduler with backlog counter
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module sdram_ctrl_if_gen #(
  parameter int ASIZE           = 23,
  parameter int INIT_PER        = 24000,
  parameter int INIT_STEP       = 20,
  parameter int INIT_REF_CNT    = 8,
  parameter int REF_PER         = 1024,
  parameter int REF_BACKLOG_MAX = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [2:0]       CMD,
  input  logic [ASIZE-1:0] ADDR,
  input  logic             CM_ACK,
  input  logic             REF_ACK,
  input  logic             INIT_RESTART,
  output logic             NOP,
  output logic             READA,
  output logic             WRITEA,
  output logic [ASIZE-1:0] SADDR,
  output logic             REFRESH,
  output logic             PRECHARGE,
  output logic             LOAD_MODE,
  output logic             INIT_REQ,
  output logic             CMD_ACK,
  output logic             REF_REQ,
  output logic             REF_URGENT,
  output logic [$clog2(REF_BACKLOG_MAX+1)-1:0] REF_PENDING,
  output logic             REF_OVF,
  output logic             Sdram_Init_Done
);

  localparam int PW     = $clog2(REF_BACKLOG_MAX + 1);
  localparam int TAIL   = (INIT_REF_CNT + 2) * INIT_STEP;
  localparam int T_LMR  = INIT_PER + TAIL;
  localparam int T_DONE = T_LMR + 1;
  localparam int CW     = $clog2(T_DONE + 1);
  localparam int TW     = $clog2(REF_PER + TAIL);

  localparam logic [CW-1:0] C_INIT_PER = CW'(INIT_PER);
  localparam logic [CW-1:0] C_T_PRE    = CW'(INIT_PER + INIT_STEP);
  localparam logic [CW-1:0] C_T_LMR    = CW'(T_LMR);
  localparam logic [CW-1:0] C_T_DONE   = CW'(T_DONE);
  localparam logic [TW-1:0] C_TMR_INIT = TW'(REF_PER - 1 + TAIL);
  localparam logic [TW-1:0] C_TMR_PER  = TW'(REF_PER - 1);
  localparam logic [PW-1:0] C_BMAX     = PW'(REF_BACKLOG_MAX);

  logic [CW-1:0]    init_cnt_q, init_cnt_d;
  logic [TW-1:0]    ref_timer_q, ref_timer_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             nop_q, nop_d, reada_q, reada_d, writea_q, writea_d;
  logic [ASIZE-1:0] saddr_q;
  logic             refresh_q, refresh_d, precharge_q, precharge_d;
  logic             load_mode_q, load_mode_d, init_req_q, init_req_d;
  logic             cmd_ack_q, cmd_ack_d;
  logic             w_done, w_ref_load, w_expire;

  assign w_done = (init_cnt_q == C_T_DONE);

  // The timer is held through the cycle after the wait ends so that the
  // first expiry lands exactly REF_PER cycles after LOAD_MODE.
  assign w_ref_load = (init_cnt_q <= C_INIT_PER);
  assign w_expire   = !w_ref_load && (ref_timer_q == '0);

  always_comb begin
    init_cnt_d  = init_cnt_q;
    ref_timer_d = ref_timer_q;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    refresh_d   = 1'b0;

    if (INIT_RESTART)
      init_cnt_d = '0;
    else if (init_cnt_q != C_T_DONE)
      init_cnt_d = init_cnt_q + CW'(1);

    init_req_d  = (init_cnt_q < C_INIT_PER);
    precharge_d = (init_cnt_q == C_T_PRE);
    load_mode_d = (init_cnt_q == C_T_LMR);
    for (int k = 2; k <= INIT_REF_CNT + 1; k++) begin
      if (init_cnt_q == CW'(INIT_PER + k * INIT_STEP))
        refresh_d = 1'b1;
    end

    nop_d     = (CMD == 3'b000);
    reada_d   = (CMD == 3'b001) && w_done;
    writea_d  = (CMD == 3'b010) && w_done;
    cmd_ack_d = CM_ACK && !cmd_ack_q;

    if (w_ref_load)
      ref_timer_d = C_TMR_INIT;
    else if (ref_timer_q == '0)
      ref_timer_d = C_TMR_PER;
    else
      ref_timer_d = ref_timer_q - TW'(1);

    if (w_expire && !REF_ACK && (pend_q == C_BMAX))
      ovf_d = 1'b1;

    if (INIT_RESTART)
      pend_d = '0;
    else if (w_expire && !REF_ACK) begin
      if (pend_q != C_BMAX)
        pend_d = pend_q + PW'(1);
    end else if (REF_ACK && !w_expire && (pend_q != '0))
      pend_d = pend_q - PW'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      init_cnt_q  <= '0;
      ref_timer_q <= '0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      nop_q       <= 1'b0;
      reada_q     <= 1'b0;
      writea_q    <= 1'b0;
      saddr_q     <= '0;
      refresh_q   <= 1'b0;
      precharge_q <= 1'b0;
      load_mode_q <= 1'b0;
      init_req_q  <= 1'b0;
      cmd_ack_q   <= 1'b0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      ref_timer_q <= ref_timer_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      nop_q       <= nop_d;
      reada_q     <= reada_d;
      writea_q    <= writea_d;
      saddr_q     <= ADDR;
      refresh_q   <= refresh_d;
      precharge_q <= precharge_d;
      load_mode_q <= load_mode_d;
      init_req_q  <= init_req_d;
      cmd_ack_q   <= cmd_ack_d;
    end
  end

  assign NOP             = nop_q;
  assign READA           = reada_q;
  assign WRITEA          = writea_q;
  assign SADDR           = saddr_q;
  assign REFRESH         = refresh_q;
  assign PRECHARGE       = precharge_q;
  assign LOAD_MODE       = load_mode_q;
  assign INIT_REQ        = init_req_q;
  assign CMD_ACK         = cmd_ack_q;
  assign REF_PENDING     = pend_q;
  assign REF_REQ         = (pend_q != '0);
  assign REF_URGENT      = (pend_q == C_BMAX);
  assign REF_OVF         = ovf_q;
  assign Sdram_Init_Done = w_done;

endmodule

`default_nettype wire

// File: tb/tb_sdram_ctrl_if_gen.sv
// ============================================================================
// tb_sdram_ctrl_if_gen : directed + randomized bench with a timeline model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_sdram_ctrl_if_gen;

  localparam int ASIZE  = 23;
  localparam int IPER   = 10;
  localparam int ISTEP  = 4;
  localparam int IRC    = 2;
  localparam int RPER   = 8;
  localparam int BMAX   = 2;
  localparam int PW     = $clog2(BMAX + 1);
  localparam int TAIL   = (IRC + 2) * ISTEP;
  localparam int T_LMR  = IPER + TAIL;
  localparam int T_DONE = T_LMR + 1;
  localparam int FIRST_EXP = IPER + TAIL + RPER;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RESET_N;
  logic [2:0]       CMD;
  logic [ASIZE-1:0] ADDR;
  logic             CM_ACK, REF_ACK, INIT_RESTART;
  logic             NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE;
  logic             INIT_REQ, CMD_ACK, REF_REQ, REF_URGENT, REF_OVF;
  logic             Sdram_Init_Done;
  logic [ASIZE-1:0] SADDR;
  logic [PW-1:0]    REF_PENDING;

  sdram_ctrl_if_gen #(
    .ASIZE(ASIZE), .INIT_PER(IPER), .INIT_STEP(ISTEP), .INIT_REF_CNT(IRC),
    .REF_PER(RPER), .REF_BACKLOG_MAX(BMAX)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CMD(CMD), .ADDR(ADDR), .CM_ACK(CM_ACK),
    .REF_ACK(REF_ACK), .INIT_RESTART(INIT_RESTART), .NOP(NOP), .READA(READA),
    .WRITEA(WRITEA), .SADDR(SADDR), .REFRESH(REFRESH), .PRECHARGE(PRECHARGE),
    .LOAD_MODE(LOAD_MODE), .INIT_REQ(INIT_REQ), .CMD_ACK(CMD_ACK),
    .REF_REQ(REF_REQ), .REF_URGENT(REF_URGENT), .REF_PENDING(REF_PENDING),
    .REF_OVF(REF_OVF), .Sdram_Init_Done(Sdram_Init_Done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: s = edges elapsed since the sequence started (reset or restart).
  int s, pend;
  bit ovf, e_nop, e_reada, e_writea, e_ref, e_pre, e_lmr, e_ireq, e_ack;
  logic [ASIZE-1:0] e_saddr;

  task automatic model_reset();
    s = 0; pend = 0; ovf = 0;
    e_nop = 0; e_reada = 0; e_writea = 0; e_ref = 0; e_pre = 0;
    e_lmr = 0; e_ireq = 0; e_ack = 0; e_saddr = '0;
  endtask

  task automatic model_edge();
    int c, k;
    bit done_pre, expire;
    c = (s < T_DONE) ? s : T_DONE;
    done_pre = (c == T_DONE);
    k = c - IPER;
    e_ireq = (c < IPER);
    e_pre  = (c == IPER + ISTEP);
    e_lmr  = (c == T_LMR);
    e_ref  = (k > 0) && (k % ISTEP == 0) && (k / ISTEP >= 2) && (k / ISTEP <= IRC + 1);
    e_nop    = (CMD == 3'd0);
    e_reada  = (CMD == 3'd1) && done_pre;
    e_writea = (CMD == 3'd2) && done_pre;
    e_saddr  = ADDR;
    e_ack    = CM_ACK && !e_ack;
    expire = (s >= FIRST_EXP) && ((s - FIRST_EXP) % RPER == 0);
    if (expire && !REF_ACK && pend == BMAX) ovf = 1;
    if (INIT_RESTART) pend = 0;
    else if (expire && !REF_ACK) begin
      if (pend < BMAX) pend++;
    end else if (REF_ACK && !expire && pend > 0) pend--;
    s = INIT_RESTART ? 0 : s + 1;
  endtask

  task automatic check_all();
    check_val("nop", NOP, e_nop);
    check_val("reada", READA, e_reada);
    check_val("writea", WRITEA, e_writea);
    check_val("saddr", SADDR, e_saddr);
    check_val("refresh", REFRESH, e_ref);
    check_val("precharge", PRECHARGE, e_pre);
    check_val("load_mode", LOAD_MODE, e_lmr);
    check_val("init_req", INIT_REQ, e_ireq);
    check_val("cmd_ack", CMD_ACK, e_ack);
    check_val("ref_pending", REF_PENDING, pend);
    check_val("ref_req", REF_REQ, pend != 0);
    check_val("ref_urgent", REF_URGENT, pend == BMAX);
    check_val("ref_ovf", REF_OVF, ovf);
    check_val("init_done", Sdram_Init_Done, s >= T_DONE);
  endtask

  int edge_n;

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
    edge_n++;
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_outs"}, {NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE,
              INIT_REQ, CMD_ACK, REF_REQ, REF_URGENT, REF_OVF, Sdram_Init_Done}, 0);
    check_val({tag, "_saddr"}, SADDR, 0);
    check_val({tag, "_pend"}, REF_PENDING, 0);
  endtask

  initial begin
    RESET_N = 1'b0; CMD = 3'd1; ADDR = '0; CM_ACK = 0; REF_ACK = 0; INIT_RESTART = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge CLK) RESET_N = 1'b1;
    edge_n = 0;

    // Init sequence with CMD=READA pending before done
    step_to(10); check_val("ireq_e10", INIT_REQ, 1);
    step_to(11); check_val("ireq_e11", INIT_REQ, 0);
    step_to(15); check_val("pre_e15", PRECHARGE, 1);
    step_to(19); check_val("ref_e19", REFRESH, 1);
    check_val("reada_early", READA, 0); check_val("nop_early", NOP, 0);
    step_to(23); check_val("ref_e23", REFRESH, 1);
    step_to(27); check_val("lmr_e27", LOAD_MODE, 1); check_val("done_e27", Sdram_Init_Done, 1);

    // Command decode after done
    CMD = 3'd1; ADDR = 23'h012345;
    step(); check_val("reada_e28", READA, 1); check_val("saddr_e28", SADDR, 23'h012345);
    CMD = 3'd5;
    step(); check_val("rsvd_e29", {NOP, READA, WRITEA}, 0);
    CMD = 3'd0;
    step(); check_val("nop_e30", NOP, 1);

    // CMD_ACK toggling under held CM_ACK
    CM_ACK = 1;
    step(); check_val("ack1", CMD_ACK, 1);
    step(); check_val("ack2", CMD_ACK, 0);
    step(); check_val("ack3", CMD_ACK, 1);
    step(); check_val("ack4", CMD_ACK, 0);
    CM_ACK = 0;
    step(); check_val("ack5", CMD_ACK, 0);

    // Refresh backlog, saturation and overflow
    check_val("pend_e35", REF_PENDING, 1); check_val("req_e35", REF_REQ, 1);
    step_to(43); check_val("pend_e43", REF_PENDING, 2); check_val("urg_e43", REF_URGENT, 1);
    step_to(51); check_val("pend_e51", REF_PENDING, 2); check_val("ovf_e51", REF_OVF, 1);
    REF_ACK = 1; step(); REF_ACK = 0;
    check_val("pend_e52", REF_PENDING, 1); check_val("urg_e52", REF_URGENT, 0);
    check_val("ovf_e52", REF_OVF, 1);

    // ACK coincident with expiry, then ACKs at zero
    step_to(58);
    REF_ACK = 1; step(); REF_ACK = 0;
    check_val("pend_coinc", REF_PENDING, 1);
    repeat (5) begin REF_ACK = 1; step(); REF_ACK = 0; end
    check_val("pend_noundf", REF_PENDING, 0);
    step_to(67); check_val("pend_e67", REF_PENDING, 1);

    // Restart after done
    INIT_RESTART = 1; step(); INIT_RESTART = 0;
    check_val("rst_done", Sdram_Init_Done, 0); check_val("rst_pend", REF_PENDING, 0);
    check_val("rst_ovf", REF_OVF, 1);
    step(); check_val("rst_ireq", INIT_REQ, 1);
    step_to(68 + 15); check_val("rst_pre", PRECHARGE, 1);
    step_to(68 + 27); check_val("rst_lmr", LOAD_MODE, 1); check_val("rst_dn", Sdram_Init_Done, 1);
    step_to(68 + 35); check_val("rst_pend1", REF_PENDING, 1);

    // Asynchronous reset in the middle of a replayed sequence
    INIT_RESTART = 1; step(); INIT_RESTART = 0;
    repeat (12) step();
    #2 RESET_N = 1'b0;
    #1 model_reset();
    check_all_zero("areset");
    check_all();
    @(negedge CLK) RESET_N = 1'b1;
    edge_n = 0;
    step_to(15); check_val("ar_pre", PRECHARGE, 1);
    step_to(27); check_val("ar_done", Sdram_Init_Done, 1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      CMD          = 3'($urandom_range(0, 7));
      ADDR         = ASIZE'($urandom);
      CM_ACK       = ($urandom_range(0, 2) != 0);
      REF_ACK      = ($urandom_range(0, 11) == 0);
      INIT_RESTART = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
